// File: rtl/gfx_bus_pkg.sv
// Shared definitions for the graphics register bus.
//
// Contents:
//   NUM_REGS / DATA_W / ADDR_W   default geometry of the register bus
//   PADDLE_1_X .. GAME_STATE     register indices. The graphics block decodes
//                                data_address with the same constants.
//   gfx_state_e                  sequencing states of the bus writer
package gfx_bus_pkg;

    localparam int NUM_REGS = 10;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;

    localparam int PADDLE_1_X = 0;
    localparam int PADDLE_1_Y = 1;
    localparam int PADDLE_2_X = 2;
    localparam int PADDLE_2_Y = 3;
    localparam int BALL_X     = 4;
    localparam int BALL_Y     = 5;
    localparam int BALL_Z     = 6;
    localparam int P1_SCORE   = 7;
    localparam int P2_SCORE   = 8;
    localparam int GAME_STATE = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        TURN    = 3'd4,
        DONE    = 3'd5
    } gfx_state_e;

endpackage

// File: rtl/gfx_bus_writer.sv
// Bus initiator for the graphics register block.
//
// On update_req, the writer snapshots the ten game-state values. It writes
// them to registers 0..NUM_REGS-1, one register per cycle. With VERIFY set,
// it then reads every register back and compares each against the snapshot.
// The responder has a 1-cycle read latency.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   update_req            one-cycle request to push a new frame. A request
//                         made while busy is held as one pending request.
//   paddle_*/ball_*/...   game-state values for registers 0..9
//   chipselect, read      bus strobes (read=0 marks a write cycle)
//   data_address          register index on the bus
//   databus               shared data bus. It is driven only in write
//                         cycles and is high-Z otherwise.
//   busy                  high while a transaction is in progress
//   done                  one-cycle pulse in the final cycle of a transaction
//   mismatch              a readback differed in the last transaction
//   mismatch_addr         first register whose readback differed
//
// Every output comes from a flop. Each output register is loaded from the
// decode of the next state, so the outputs line up with the state register.
module gfx_bus_writer #(
    parameter int NUM_REGS = gfx_bus_pkg::NUM_REGS,
    parameter int DATA_W   = gfx_bus_pkg::DATA_W,
    parameter int ADDR_W   = gfx_bus_pkg::ADDR_W,
    parameter bit VERIFY   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update_req,
    input  logic [DATA_W-1:0] paddle_1_x,
    input  logic [DATA_W-1:0] paddle_1_y,
    input  logic [DATA_W-1:0] paddle_2_x,
    input  logic [DATA_W-1:0] paddle_2_y,
    input  logic [DATA_W-1:0] ball_x,
    input  logic [DATA_W-1:0] ball_y,
    input  logic [DATA_W-1:0] ball_z,
    input  logic [DATA_W-1:0] p1_score,
    input  logic [DATA_W-1:0] p2_score,
    input  logic [DATA_W-1:0] game_state,
    output logic              chipselect,
    output logic              read,
    output logic [ADDR_W-1:0] data_address,
    inout  wire  [DATA_W-1:0] databus,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_addr
);
    import gfx_bus_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    // Game-state inputs as an array indexed by register number.
    // NUM_REGS is expected to stay at 10, one entry per named input.
    logic [DATA_W-1:0] in_vec   [NUM_REGS];
    logic [DATA_W-1:0] snap_vec [NUM_REGS];

    assign in_vec[PADDLE_1_X] = paddle_1_x;
    assign in_vec[PADDLE_1_Y] = paddle_1_y;
    assign in_vec[PADDLE_2_X] = paddle_2_x;
    assign in_vec[PADDLE_2_Y] = paddle_2_y;
    assign in_vec[BALL_X]     = ball_x;
    assign in_vec[BALL_Y]     = ball_y;
    assign in_vec[BALL_Z]     = ball_z;
    assign in_vec[P1_SCORE]   = p1_score;
    assign in_vec[P2_SCORE]   = p2_score;
    assign in_vec[GAME_STATE] = game_state;

    gfx_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              pending_reg, pending_next;
    logic              mismatch_next;
    logic [ADDR_W-1:0] mismatch_addr_next;
    logic              capture;

    logic              drive_reg, drive_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              cs_next, read_next, busy_next, done_next;
    logic [ADDR_W-1:0] addr_next;

    logic idx_last;
    assign idx_last = (idx_reg == LAST_IDX);

    // Snapshot registers. They are loaded together whenever a transaction
    // starts, from IDLE or directly from DONE when a request is pending.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_snap
            logic [DATA_W-1:0] snap_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    snap_reg <= '0;
                end else if (capture) begin
                    snap_reg <= in_vec[gi];
                end
            end
            assign snap_vec[gi] = snap_reg;
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        state_next         = state_reg;
        idx_next           = idx_reg;
        pending_next       = pending_reg;
        mismatch_next      = mismatch;
        mismatch_addr_next = mismatch_addr;
        capture            = 1'b0;

        // A request made while busy is remembered once. Further requests
        // merge into it.
        if (update_req && (state_reg != IDLE)) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (update_req) begin
                    capture            = 1'b1;
                    mismatch_next      = 1'b0;
                    mismatch_addr_next = '0;
                    idx_next           = '0;
                    state_next         = WRITE;
                end
            end
            WRITE: begin
                if (idx_last) begin
                    idx_next   = '0;
                    state_next = VERIFY ? RD_REQ : DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            RD_REQ: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                // The responder drives its data during this cycle. The value
                // is taken at the closing edge, and only the first failure
                // is recorded.
                if ((databus != snap_vec[idx_reg]) && !mismatch) begin
                    mismatch_next      = 1'b1;
                    mismatch_addr_next = idx_reg;
                end
                if (idx_last) begin
                    state_next = TURN;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = RD_REQ;
                end
            end
            TURN: begin
                state_next = DONE;
            end
            DONE: begin
                // A request arriving in this very cycle counts as pending,
                // so no request is lost on the way back to IDLE.
                if (pending_reg || update_req) begin
                    pending_next       = 1'b0;
                    capture            = 1'b1;
                    mismatch_next      = 1'b0;
                    mismatch_addr_next = '0;
                    idx_next           = '0;
                    state_next         = WRITE;
                end else begin
                    idx_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                idx_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output decode of the next state. These values are registered below.
    always_comb begin
        cs_next    = (state_next == WRITE) || (state_next == RD_REQ);
        read_next  = (state_next != WRITE);
        drive_next = (state_next == WRITE);
        addr_next  = idx_next;
        // When a new snapshot is being captured, its values are not yet in
        // the snapshot registers, so take the first word from the inputs.
        wdata_next = capture ? in_vec[idx_next] : snap_vec[idx_next];
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            pending_reg   <= 1'b0;
            mismatch      <= 1'b0;
            mismatch_addr <= '0;
            chipselect    <= 1'b0;
            read          <= 1'b1;
            data_address  <= '0;
            drive_reg     <= 1'b0;
            wdata_reg     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            pending_reg   <= pending_next;
            mismatch      <= mismatch_next;
            mismatch_addr <= mismatch_addr_next;
            chipselect    <= cs_next;
            read          <= read_next;
            data_address  <= addr_next;
            drive_reg     <= drive_next;
            wdata_reg     <= wdata_next;
            busy          <= busy_next;
            done          <= done_next;
        end
    end

    // The drive enable comes from a flop that reset clears asynchronously,
    // so an aborted transaction releases the bus at once.
    assign databus = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_gfx_bus_writer.sv
// Scoreboard bench for gfx_bus_writer.
// u_nv (VERIFY=0) and u_v (VERIFY=1) are exercised in separate phases.
// u_v sees a behavioural register-file responder with a 1-cycle read latency.
// The responder can corrupt the readback of selected addresses.
module tb_gfx_bus_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_nv = 1'b0, req_v = 1'b0;
    logic [15:0] in_val [10];

    logic        cs_nv, rd_nv, busy_nv, done_nv, mm_nv;
    logic [3:0]  addr_nv, maddr_nv;
    wire  [15:0] bus_nv;
    logic        cs_v, rd_v, busy_v, done_v, mm_v;
    logic [3:0]  addr_v, maddr_v;
    wire  [15:0] bus_v;

    gfx_bus_writer #(.VERIFY(1'b0)) u_nv (
        .clk(clk), .rst(rst), .update_req(req_nv),
        .paddle_1_x(in_val[0]), .paddle_1_y(in_val[1]), .paddle_2_x(in_val[2]),
        .paddle_2_y(in_val[3]), .ball_x(in_val[4]), .ball_y(in_val[5]),
        .ball_z(in_val[6]), .p1_score(in_val[7]), .p2_score(in_val[8]),
        .game_state(in_val[9]),
        .chipselect(cs_nv), .read(rd_nv), .data_address(addr_nv), .databus(bus_nv),
        .busy(busy_nv), .done(done_nv), .mismatch(mm_nv), .mismatch_addr(maddr_nv)
    );

    gfx_bus_writer #(.VERIFY(1'b1)) u_v (
        .clk(clk), .rst(rst), .update_req(req_v),
        .paddle_1_x(in_val[0]), .paddle_1_y(in_val[1]), .paddle_2_x(in_val[2]),
        .paddle_2_y(in_val[3]), .ball_x(in_val[4]), .ball_y(in_val[5]),
        .ball_z(in_val[6]), .p1_score(in_val[7]), .p2_score(in_val[8]),
        .game_state(in_val[9]),
        .chipselect(cs_v), .read(rd_v), .data_address(addr_v), .databus(bus_v),
        .busy(busy_v), .done(done_v), .mismatch(mm_v), .mismatch_addr(maddr_v)
    );

    // Responder: a register file. Read data appears in the cycle after the
    // read request, and the responder drives only in that cycle.
    logic [15:0] mem [16];
    logic        resp_en = 1'b0;
    logic [15:0] resp_data = '0;
    logic [15:0] corrupt_mask = '0;
    logic [15:0] corrupt_x = '0;

    assign bus_v = resp_en ? resp_data : 16'bz;

    always @(posedge clk) begin
        resp_en   <= cs_v && rd_v;
        resp_data <= corrupt_mask[addr_v] ? (mem[addr_v] ^ corrupt_x) : mem[addr_v];
        if (cs_v && !rd_v) mem[addr_v] <= bus_v;
    end

    // Scoreboard.
    typedef struct packed {
        logic        inst;
        logic        rd;
        logic [3:0]  addr;
        logic [15:0] data;
    } bus_ev_t;

    typedef struct packed {
        logic        inst;
        logic        mm;
        logic [3:0]  maddr;
        logic [7:0]  cycles;
    } done_ev_t;

    bus_ev_t  exp_bus[$];
    done_ev_t exp_done[$];
    int       busy_cnt [2];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model. It writes every register in order and, when verify is
    // set, reads every register back in order. The first corrupted address is
    // reported as the mismatch.
    task automatic expect_txn(input int inst);
        bus_ev_t  e;
        done_ev_t d;
        bit       verify;
        int       first_bad;
        verify    = (inst == 1);
        first_bad = -1;
        for (int i = 0; i < 10; i++) begin
            e = '{inst: inst[0], rd: 1'b0, addr: i[3:0], data: in_val[i]};
            exp_bus.push_back(e);
        end
        if (verify) begin
            for (int i = 0; i < 10; i++) begin
                e = '{inst: 1'b1, rd: 1'b1, addr: i[3:0], data: 16'h0};
                exp_bus.push_back(e);
                if (first_bad < 0 && corrupt_mask[i]) first_bad = i;
            end
        end
        d.inst   = inst[0];
        d.mm     = (first_bad >= 0);
        d.maddr  = (first_bad >= 0) ? first_bad[3:0] : 4'd0;
        d.cycles = verify ? 8'd32 : 8'd11;
        exp_done.push_back(d);
    endtask

    task automatic mon(input int inst, input logic c, input logic r, input logic [3:0] a,
                       input logic [15:0] dat, input logic b, input logic dn,
                       input logic m, input logic [3:0] ma);
        bus_ev_t  e;
        done_ev_t d;
        if (!b) begin
            busy_cnt[inst] = 0;
            check("cs_while_idle", {31'd0, c}, 32'd0);
        end else begin
            busy_cnt[inst]++;
        end
        if (c) begin
            if (exp_bus.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_bus_cycle: inst=%0d read=%0d addr=%0d, expected none", inst, r, a);
            end else begin
                e = exp_bus.pop_front();
                check("bus_inst", inst, {31'd0, e.inst});
                check("bus_read", {31'd0, r}, {31'd0, e.rd});
                check("bus_addr", {28'd0, a}, {28'd0, e.addr});
                if (!e.rd) check("write_data", {16'd0, dat}, {16'd0, e.data});
            end
        end
        if (dn) begin
            if (exp_done.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: inst=%0d, expected no done pulse", inst);
            end else begin
                d = exp_done.pop_front();
                check("done_inst", inst, {31'd0, d.inst});
                check("mismatch", {31'd0, m}, {31'd0, d.mm});
                check("mismatch_addr", {28'd0, ma}, {28'd0, d.maddr});
                check("busy_cycles", busy_cnt[inst], {24'd0, d.cycles});
            end
            busy_cnt[inst] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, cs_nv, rd_nv, addr_nv, bus_nv, busy_nv, done_nv, mm_nv, maddr_nv);
        mon(1, cs_v, rd_v, addr_v, bus_v, busy_v, done_v, mm_v, maddr_v);
        // The master drives only in write cycles. Those cycles must never
        // overlap the responder's drive cycle.
        if (resp_en) begin
            check("contention", {31'd0, cs_v && !rd_v}, 32'd0);
            check("resp_bus_value", {16'd0, bus_v}, {16'd0, resp_data});
        end
    end

    // Stimulus helpers.
    task automatic pulse_req(input int inst);
        @(negedge clk);
        if (inst == 0) req_nv = 1'b1; else req_v = 1'b1;
        @(negedge clk);
        req_nv = 1'b0;
        req_v  = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((inst == 0) ? busy_nv : busy_v) && n < 300);
        if (n >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: inst=%0d still busy after %0d cycles", inst, n);
        end
        check("events_drained", exp_bus.size() + exp_done.size(), 32'd0);
        $display("[TB] txn inst=%0d complete, mismatch=%0d addr=%0d",
                 inst, (inst == 0) ? mm_nv : mm_v, (inst == 0) ? maddr_nv : maddr_v);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 10; i++) in_val[i] = 16'($urandom_range(0, 65535));
    endtask

    task automatic set_directed();
        in_val[0] = 16'd100; in_val[1] = 16'd110; in_val[2] = 16'd700;
        in_val[3] = 16'd110; in_val[4] = 16'd320; in_val[5] = 16'd240;
        in_val[6] = 16'd0;   in_val[7] = 16'd3;   in_val[8] = 16'd1;
        in_val[9] = 16'd2;
    endtask

    task automatic rand_corruption();
        if ($urandom_range(0, 1) == 0) begin
            corrupt_mask = '0;
        end else begin
            corrupt_mask = {6'd0, 10'($urandom_range(1, 1023))};
        end
        corrupt_x = 16'($urandom_range(1, 65535));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        for (int i = 0; i < 10; i++) in_val[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1 rst = 1'b0;
        #2;
        check("rst_cs_nv", {31'd0, cs_nv}, 32'd0);
        check("rst_read_nv", {31'd0, rd_nv}, 32'd1);
        check("rst_busy_nv", {31'd0, busy_nv}, 32'd0);
        check("rst_cs_v", {31'd0, cs_v}, 32'd0);
        check("rst_read_v", {31'd0, rd_v}, 32'd1);
        check("rst_addr_v", {28'd0, addr_v}, 32'd0);
        check("rst_busy_v", {31'd0, busy_v}, 32'd0);
        check("rst_done_v", {31'd0, done_v}, 32'd0);
        check("rst_mm_v", {31'd0, mm_v}, 32'd0);
        check("rst_maddr_v", {28'd0, maddr_v}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write-only instance: a directed frame, then random frames.
        set_directed();
        expect_txn(0);
        pulse_req(0);
        wait_idle(0);
        for (int t = 0; t < 4; t++) begin
            rand_inputs();
            expect_txn(0);
            pulse_req(0);
            wait_idle(0);
        end

        // Verifying instance: a clean directed frame.
        set_directed();
        corrupt_mask = '0;
        expect_txn(1);
        pulse_req(1);
        wait_idle(1);

        // Reg 5 (240) reads back as 0.
        corrupt_mask = 16'h0020;
        corrupt_x    = 16'h00F0;
        expect_txn(1);
        pulse_req(1);
        wait_idle(1);

        // Random frames with random corruption and 0..2 merged extra requests.
        for (int t = 0; t < 8; t++) begin
            rand_inputs();
            rand_corruption();
            extra = $urandom_range(0, 2);
            expect_txn(1);
            if (extra > 0) expect_txn(1);
            pulse_req(1);
            repeat (2) @(negedge clk);
            for (int k = 0; k < extra; k++) pulse_req(1);
            wait_idle(1);
        end

        // Three requests while busy produce exactly one follow-up frame. That
        // frame uses the inputs present at the DONE edge.
        rand_inputs();
        rand_corruption();
        expect_txn(1);
        pulse_req(1);
        repeat (2) @(negedge clk);
        rand_inputs();
        expect_txn(1);
        for (int k = 0; k < 3; k++) begin
            pulse_req(1);
            @(negedge clk);
        end
        wait_idle(1);

        // Reset while the writer is at address 4 aborts the frame.
        rand_inputs();
        corrupt_mask = '0;
        expect_txn(1);
        pulse_req(1);
        n = 0;
        while (!(cs_v && !rd_v && addr_v == 4'd4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_addr4", {31'd0, n < 50}, 32'd1);
        #2 rst = 1'b0;
        exp_bus.delete();
        exp_done.delete();
        #1;
        check("abort_cs", {31'd0, cs_v}, 32'd0);
        check("abort_busy", {31'd0, busy_v}, 32'd0);
        check("abort_done", {31'd0, done_v}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rand_inputs();
        expect_txn(1);
        pulse_req(1);
        wait_idle(1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gfx_bus_writer.md
Name: gfx_bus_writer

Overview:
- Bus initiator for the graphics register block. Drives `chipselect`, `read`, `data_address` and the shared bidirectional `databus`.
- On request, snapshots the game-state values, writes them to graphics registers 0..9, and optionally reads each one back to verify it.
- Sits between the game-logic core and the graphics block on the 16-bit register bus.

Parameters:
- NUM_REGS, 10, registers written per update (addresses 0..NUM_REGS-1)
- DATA_W, 16, databus width
- ADDR_W, 4, data_address width
- VERIFY, 1, 1 = read back every register after the write pass and compare

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- update_req  input  1  one-cycle request to push a new frame of state
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  input  16 each  paddle positions (regs 0-3)
- ball_x, ball_y, ball_z  input  16 each  ball position (regs 4-6)
- p1_score, p2_score, game_state  input  16 each  regs 7-9
- chipselect  output  1  bus select
- read  output  1  1 = read cycle, 0 = write cycle
- data_address  output  ADDR_W  register index
- databus  inout  DATA_W  driven only in WRITE state, else high-Z
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at end of transaction
- mismatch  output  1  sticky: readback differed in the last transaction
- mismatch_addr  output  ADDR_W  first failing address

Behaviour:
- Reset (async, while rst=0):
  - state IDLE
  - chipselect=0, read=1, data_address=0, databus=Z
  - busy=0, done=0, mismatch=0, mismatch_addr=0, pending=0, all snapshot regs=0
- All outputs are registered; reset release is synchronous to clk.
- IDLE: on update_req=1 at a rising edge:
  - capture all 10 inputs into snapshot regs
  - clear mismatch and mismatch_addr
  - idx=0, go to WRITE
- WRITE, one cycle per register:
  - chipselect=1, read=0, data_address=idx, databus=snapshot[idx]
  - idx increments each cycle
  - after idx=NUM_REGS-1: go to RD_REQ with idx=0 if VERIFY, else DONE
- RD_REQ:
  - chipselect=1, read=1, data_address=idx, databus=Z
  - go to RD_WAIT
- RD_WAIT:
  - chipselect=0, read=1, databus=Z
  - sample databus at the closing edge; the responder has a 1-cycle read latency
  - if sampled data != snapshot[idx] and mismatch=0: set mismatch=1, mismatch_addr=idx
  - if idx=NUM_REGS-1: go to TURN, else idx+1 and go to RD_REQ
- TURN: one idle cycle, chipselect=0, databus=Z, so the responder releases the bus. Go to DONE.
- DONE:
  - done=1 for exactly one cycle
  - if pending=1: clear pending, take a fresh snapshot, clear mismatch, go to WRITE
  - else go to IDLE
- busy=1 in every state except IDLE.
- Cycle counts from the accepting edge to the done pulse:
  - VERIFY=0: 10 write cycles + 1 DONE cycle = busy for 11 cycles
  - VERIFY=1: 10 + 20 + 1 + 1 = 32 cycles
- update_req while busy (including in DONE) sets pending. It is one-deep, so extra requests merge into one.
- update_req in the same cycle that DONE leaves for IDLE is accepted normally.
- databus must never be driven while chipselect&read is asserted, nor in the cycle after a read request.
- idx is ADDR_W wide and never exceeds NUM_REGS-1; there is no wrap beyond that.
- Reset mid-transaction aborts immediately; the bus floats and no done pulse is produced.

Decomposition:
- Shared package `gfx_bus_pkg`:
  - register index constants PADDLE_1_X=0 … GAME_STATE=9, also used by the graphics block
  - NUM_REGS, DATA_W, ADDR_W
  - state encoding IDLE/WRITE/RD_REQ/RD_WAIT/TURN/DONE
- Single module. The tri-state driver is an assign inside it; no natural sub-module.

Test Plan:
- Reset, then update_req with paddle_1_x=100 … game_state=2 (VERIFY=0) -> addresses 0..9 written on consecutive cycles, read=0, correct data on each; done pulses 11 cycles after acceptance; bus Z afterwards.
- VERIFY=1 with a behavioural responder (1-cycle read latency) -> 10 writes, 10 read pairs, mismatch=0, done at cycle 32.
- Responder corrupts reg 5 readback (returns 0 instead of 240) -> mismatch=1, mismatch_addr=5, done still pulses.
- update_req asserted three times during busy -> exactly one extra transaction starts directly after DONE, using inputs sampled at that DONE edge.
- rst pulled low mid-WRITE at idx=4 -> chipselect=0 and databus=Z asynchronously, busy=0, no done; a new request after release restarts at address 0.
- Bus-contention checker throughout: master drive and responder drive never overlap, including across the read-to-TURN-to-WRITE boundaries.
